// File: rtl/tmu2_vinterp.sv
// tmu2_vinterp: vertical interpolator of the TMU2 pipeline.
// Takes one destination-square record and emits one line record per
// destination row. Left-edge texture coordinates are stepped per line with a
// quotient/remainder (Bresenham-style) interpolator whose divisor is the
// square height. Horizontal diff terms are latched and forwarded unchanged.
module tmu2_vinterp (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  output logic                busy,

  input  logic                pipe_stb_i,
  output logic                pipe_ack_o,
  input  logic signed [11:0]  x,
  input  logic signed [11:0]  y,
  input  logic signed [17:0]  tsx,
  input  logic signed [17:0]  tsy,
  input  logic                vdiff_x_positive,
  input  logic [16:0]         vdiff_x_q,
  input  logic [16:0]         vdiff_x_r,
  input  logic                vdiff_y_positive,
  input  logic [16:0]         vdiff_y_q,
  input  logic [16:0]         vdiff_y_r,
  input  logic                hdiff_x_positive,
  input  logic [16:0]         hdiff_x_q,
  input  logic [16:0]         hdiff_x_r,
  input  logic                hdiff_y_positive,
  input  logic [16:0]         hdiff_y_q,
  input  logic [16:0]         hdiff_y_r,
  input  logic [10:0]         dst_squareh,

  output logic                pipe_stb_o,
  input  logic                pipe_ack_i,
  output logic signed [11:0]  ox,
  output logic signed [11:0]  oy,
  output logic signed [17:0]  otsx,
  output logic signed [17:0]  otsy,
  output logic                diff_x_positive,
  output logic [16:0]         diff_x_q,
  output logic [16:0]         diff_x_r,
  output logic                diff_y_positive,
  output logic [16:0]         diff_y_q,
  output logic [16:0]         diff_y_r
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic signed [11:0] ox_q, ox_d, oy_q, oy_d;
  logic signed [17:0] otsx_q, otsx_d, otsy_q, otsy_d;
  logic [17:0]        errx_q, errx_d, erry_q, erry_d;
  logic [10:0]        rem_q, rem_d, sqh_q, sqh_d;
  logic               vxp_q, vxp_d, vyp_q, vyp_d;
  logic [16:0]        vxq_q, vxq_d, vxr_q, vxr_d, vyq_q, vyq_d, vyr_q, vyr_d;
  logic               hxp_q, hxp_d, hyp_q, hyp_d;
  logic [16:0]        hxq_q, hxq_d, hxr_q, hxr_d, hyq_q, hyq_d, hyr_q, hyr_d;

  logic [17:0]        div, sum_x, sum_y;
  logic               carry_x, carry_y;

  // Advance a coordinate by q, or q+1 when the error term overflowed the divisor.
  function automatic logic signed [17:0] step_coord(input logic signed [17:0] o,
                                                    input logic              pos,
                                                    input logic [16:0]       q,
                                                    input logic              carry);
    logic signed [17:0] inc;
    inc = signed'({1'b0, q} + {17'd0, carry});
    step_coord = pos ? o + inc : o - inc;
  endfunction

  assign busy       = (state_q == BUSY);
  assign pipe_stb_o = busy;
  assign pipe_ack_o = ~busy;

  assign ox              = ox_q;
  assign oy              = oy_q;
  assign otsx            = otsx_q;
  assign otsy            = otsy_q;
  assign diff_x_positive = hxp_q;
  assign diff_x_q        = hxq_q;
  assign diff_x_r        = hxr_q;
  assign diff_y_positive = hyp_q;
  assign diff_y_q        = hyq_q;
  assign diff_y_r        = hyr_q;

  // Next-state logic: load a square in IDLE, step one line per accepted record in BUSY.
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;    oy_d    = oy_q;
    otsx_d  = otsx_q;  otsy_d  = otsy_q;
    errx_d  = errx_q;  erry_d  = erry_q;
    rem_d   = rem_q;   sqh_d   = sqh_q;
    vxp_d   = vxp_q;   vxq_d   = vxq_q;  vxr_d = vxr_q;
    vyp_d   = vyp_q;   vyq_d   = vyq_q;  vyr_d = vyr_q;
    hxp_d   = hxp_q;   hxq_d   = hxq_q;  hxr_d = hxr_q;
    hyp_d   = hyp_q;   hyq_d   = hyq_q;  hyr_d = hyr_q;

    // A zero divisor makes every step carry, which is the intended degenerate behaviour.
    div     = {7'd0, sqh_q};
    sum_x   = errx_q + {1'b0, vxr_q};
    sum_y   = erry_q + {1'b0, vyr_q};
    carry_x = (sum_x >= div);
    carry_y = (sum_y >= div);

    case (state_q)
      IDLE: begin
        if (pipe_stb_i) begin
          state_d = BUSY;
          ox_d    = x;
          oy_d    = y;
          otsx_d  = tsx;
          otsy_d  = tsy;
          errx_d  = '0;
          erry_d  = '0;
          sqh_d   = dst_squareh;
          rem_d   = dst_squareh - 11'd1;
          vxp_d   = vdiff_x_positive;  vxq_d = vdiff_x_q;  vxr_d = vdiff_x_r;
          vyp_d   = vdiff_y_positive;  vyq_d = vdiff_y_q;  vyr_d = vdiff_y_r;
          hxp_d   = hdiff_x_positive;  hxq_d = hdiff_x_q;  hxr_d = hdiff_x_r;
          hyp_d   = hdiff_y_positive;  hyq_d = hdiff_y_q;  hyr_d = hdiff_y_r;
        end
      end
      BUSY: begin
        if (pipe_ack_i) begin
          if (rem_q == 11'd0) begin
            state_d = IDLE;
          end else begin
            rem_d  = rem_q - 11'd1;
            oy_d   = oy_q + 12'sd1;
            otsx_d = step_coord(otsx_q, vxp_q, vxq_q, carry_x);
            otsy_d = step_coord(otsy_q, vyp_q, vyq_q, carry_y);
            errx_d = carry_x ? sum_x - div : sum_x;
            erry_d = carry_y ? sum_y - div : sum_y;
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset abandons any square in progress.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ox_q    <= '0;  oy_q   <= '0;
      otsx_q  <= '0;  otsy_q <= '0;
      errx_q  <= '0;  erry_q <= '0;
      rem_q   <= '0;  sqh_q  <= '0;
      vxp_q   <= 1'b0; vxq_q <= '0; vxr_q <= '0;
      vyp_q   <= 1'b0; vyq_q <= '0; vyr_q <= '0;
      hxp_q   <= 1'b0; hxq_q <= '0; hxr_q <= '0;
      hyp_q   <= 1'b0; hyq_q <= '0; hyr_q <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;    oy_q   <= oy_d;
      otsx_q  <= otsx_d;  otsy_q <= otsy_d;
      errx_q  <= errx_d;  erry_q <= erry_d;
      rem_q   <= rem_d;   sqh_q  <= sqh_d;
      vxp_q   <= vxp_d;   vxq_q  <= vxq_d;  vxr_q <= vxr_d;
      vyp_q   <= vyp_d;   vyq_q  <= vyq_d;  vyr_q <= vyr_d;
      hxp_q   <= hxp_d;   hxq_q  <= hxq_d;  hxr_q <= hxr_d;
      hyp_q   <= hyp_d;   hyq_q  <= hyq_d;  hyr_q <= hyr_d;
    end
  end

endmodule

// File: tb/tb_tmu2_vinterp.sv
// Bench for tmu2_vinterp: scenario tasks with randomized squares checked
// against a closed-form model of the per-line texture coordinates.
module tb_tmu2_vinterp;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               busy, pipe_stb_i = 1'b0, pipe_ack_o;
  logic signed [11:0] x = '0, y = '0;
  logic signed [17:0] tsx = '0, tsy = '0;
  logic               vdiff_x_positive = 1'b0, vdiff_y_positive = 1'b0;
  logic [16:0]        vdiff_x_q = '0, vdiff_x_r = '0, vdiff_y_q = '0, vdiff_y_r = '0;
  logic               hdiff_x_positive = 1'b0, hdiff_y_positive = 1'b0;
  logic [16:0]        hdiff_x_q = '0, hdiff_x_r = '0, hdiff_y_q = '0, hdiff_y_r = '0;
  logic [10:0]        dst_squareh = '0;
  logic               pipe_stb_o, pipe_ack_i = 1'b0;
  logic signed [11:0] ox, oy;
  logic signed [17:0] otsx, otsy;
  logic               diff_x_positive, diff_y_positive;
  logic [16:0]        diff_x_q, diff_x_r, diff_y_q, diff_y_r;

  tmu2_vinterp dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .busy(busy),
    .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
    .x(x), .y(y), .tsx(tsx), .tsy(tsy),
    .vdiff_x_positive(vdiff_x_positive), .vdiff_x_q(vdiff_x_q), .vdiff_x_r(vdiff_x_r),
    .vdiff_y_positive(vdiff_y_positive), .vdiff_y_q(vdiff_y_q), .vdiff_y_r(vdiff_y_r),
    .hdiff_x_positive(hdiff_x_positive), .hdiff_x_q(hdiff_x_q), .hdiff_x_r(hdiff_x_r),
    .hdiff_y_positive(hdiff_y_positive), .hdiff_y_q(hdiff_y_q), .hdiff_y_r(hdiff_y_r),
    .dst_squareh(dst_squareh),
    .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
    .ox(ox), .oy(oy), .otsx(otsx), .otsy(otsy),
    .diff_x_positive(diff_x_positive), .diff_x_q(diff_x_q), .diff_x_r(diff_x_r),
    .diff_y_positive(diff_y_positive), .diff_y_q(diff_y_q), .diff_y_r(diff_y_r)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic signed [11:0] x, y;
    logic signed [17:0] tsx, tsy;
    bit vxp; int vxq, vxr;
    bit vyp; int vyq, vyr;
    bit hxp; int hxq, hxr;
    bit hyp; int hyq, hyr;
    int h;
  } sq_t;

  typedef struct {
    logic [59:0] pos;
    logic [69:0] dif;
  } rec_t;

  rec_t recs[$];

  // Left edge after k lines: k whole steps plus floor(k*r/h) extra units.
  function automatic logic [17:0] lin(input logic [17:0] t0, input bit pos,
                                      input int q, input int r, input int h, input int k);
    longint d;
    d = longint'(k) * longint'(q) + (longint'(k) * longint'(r)) / longint'(h);
    return pos ? t0 + 18'(d) : t0 - 18'(d);
  endfunction

  function automatic logic [59:0] exp_pos(input sq_t s, input int k);
    logic [11:0] yy;
    yy = 12'(int'(s.y) + k);
    return {s.x, yy, lin(s.tsx, s.vxp, s.vxq, s.vxr, s.h, k),
            lin(s.tsy, s.vyp, s.vyq, s.vyr, s.h, k)};
  endfunction

  function automatic logic [69:0] exp_dif(input sq_t s);
    return {s.hxp, 17'(s.hxq), 17'(s.hxr), s.hyp, 17'(s.hyq), 17'(s.hyr)};
  endfunction

  function automatic sq_t rand_sq(input int hmin, input int hmax);
    sq_t s;
    s.h   = int'($urandom_range(hmax, hmin));
    s.x   = 12'($urandom);  s.y   = 12'($urandom);
    s.tsx = 18'($urandom);  s.tsy = 18'($urandom);
    s.vxp = 1'($urandom);   s.vxq = int'($urandom_range(131071, 0)); s.vxr = int'($urandom_range(s.h - 1, 0));
    s.vyp = 1'($urandom);   s.vyq = int'($urandom_range(131071, 0)); s.vyr = int'($urandom_range(s.h - 1, 0));
    s.hxp = 1'($urandom);   s.hxq = int'($urandom_range(131071, 0)); s.hxr = int'($urandom_range(131071, 0));
    s.hyp = 1'($urandom);   s.hyq = int'($urandom_range(131071, 0)); s.hyr = int'($urandom_range(131071, 0));
    return s;
  endfunction

  function automatic logic [59:0] cur_pos();
    return {ox, oy, otsx, otsy};
  endfunction

  function automatic logic [69:0] cur_dif();
    return {diff_x_positive, diff_x_q, diff_x_r, diff_y_positive, diff_y_q, diff_y_r};
  endfunction

  task automatic drive_inputs(input sq_t s);
    x = s.x; y = s.y; tsx = s.tsx; tsy = s.tsy;
    vdiff_x_positive = s.vxp; vdiff_x_q = 17'(s.vxq); vdiff_x_r = 17'(s.vxr);
    vdiff_y_positive = s.vyp; vdiff_y_q = 17'(s.vyq); vdiff_y_r = 17'(s.vyr);
    hdiff_x_positive = s.hxp; hdiff_x_q = 17'(s.hxq); hdiff_x_r = 17'(s.hxr);
    hdiff_y_positive = s.hyp; hdiff_y_q = 17'(s.hyq); hdiff_y_r = 17'(s.hyr);
    dst_squareh = 11'(s.h);
  endtask

  // Present a square for one cycle (called #1 after a rising edge while idle),
  // then scramble the data inputs so anything sampled while busy would show up.
  task automatic load_square(input sq_t s);
    drive_inputs(s);
    pipe_stb_i = 1'b1;
    @(posedge sys_clk); #1;
    pipe_stb_i = 1'b0;
    drive_inputs(rand_sq(1, 2047));
  endtask

  // Accept line records with a random stall rate until the block goes idle.
  task automatic collect(input int stall_pct);
    rec_t r;
    int   n;
    recs.delete();
    n = 0;
    while (pipe_stb_o && n < 20000) begin
      pipe_ack_i = (int'($urandom_range(99, 0)) >= stall_pct);
      if (pipe_ack_i) begin
        r.pos = cur_pos();
        r.dif = cur_dif();
        recs.push_back(r);
      end
      @(posedge sys_clk); #1;
      n++;
    end
    pipe_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, pipe_stb_o, pipe_ack_o} !== 3'b001) begin
      bad++; $display("FAIL reset_hs got=%b exp=001", {busy, pipe_stb_o, pipe_ack_o});
    end
    total++;
    if ({cur_pos(), cur_dif()} !== 130'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {cur_pos(), cur_dif()});
    end
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_basic();
    sq_t s;
    logic [17:0] ex_tx [4];
    logic [17:0] ex_ty [4];
    ex_tx = '{18'd100, 18'd103, 18'd106, 18'd109};
    ex_ty = '{18'd50, 18'd48, 18'd45, 18'd42};
    s = rand_sq(4, 4);
    s.x = 12'sd10; s.y = 12'sd20; s.tsx = 18'sd100; s.tsy = 18'sd50;
    s.vxp = 1'b1; s.vxq = 3; s.vxr = 1;
    s.vyp = 1'b0; s.vyq = 2; s.vyr = 3;
    load_square(s);
    collect(0);
    total++;
    if (recs.size() != 4) begin
      bad++; $display("FAIL basic_count got=%0d exp=4", recs.size());
    end
    for (int k = 0; k < recs.size() && k < 4; k++) begin
      total++;
      if (recs[k].pos !== {12'd10, 12'(20 + k), ex_tx[k], ex_ty[k]}) begin
        bad++; $display("FAIL basic_line%0d got=%h exp=%h", k, recs[k].pos,
                        {12'd10, 12'(20 + k), ex_tx[k], ex_ty[k]});
      end
    end
    total++;
    if ({busy, pipe_ack_o} !== 2'b01) begin
      bad++; $display("FAIL basic_idle got=%b exp=01", {busy, pipe_ack_o});
    end
  endtask

  task automatic test_stall();
    sq_t s;
    logic [59:0] first, snap;
    s = rand_sq(4, 4);
    load_square(s);
    pipe_ack_i = 1'b1;
    first = cur_pos();
    @(posedge sys_clk); #1;
    pipe_ack_i = 1'b0;
    snap = cur_pos();
    total++;
    if (first !== exp_pos(s, 0)) begin
      bad++; $display("FAIL stall_line0 got=%h exp=%h", first, exp_pos(s, 0));
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
      total++;
      if ({cur_pos(), pipe_stb_o, pipe_ack_o} !== {snap, 2'b10}) begin
        bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i,
                        {cur_pos(), pipe_stb_o, pipe_ack_o}, {snap, 2'b10});
      end
    end
    collect(0);
    total++;
    if (recs.size() != 3) begin
      bad++; $display("FAIL stall_count got=%0d exp=3", recs.size());
    end
    for (int k = 0; k < recs.size(); k++) begin
      total++;
      if (recs[k].pos !== exp_pos(s, k + 1)) begin
        bad++; $display("FAIL stall_line%0d got=%h exp=%h", k + 1, recs[k].pos, exp_pos(s, k + 1));
      end
    end
  endtask

  task automatic test_single_b2b();
    sq_t s1, s2;
    s1 = rand_sq(1, 1);
    s2 = rand_sq(3, 3);
    load_square(s1);
    total++;
    if ({pipe_stb_o, cur_pos(), cur_dif()} !== {1'b1, exp_pos(s1, 0), exp_dif(s1)}) begin
      bad++; $display("FAIL single_rec got=%h exp=%h", {pipe_stb_o, cur_pos(), cur_dif()},
                      {1'b1, exp_pos(s1, 0), exp_dif(s1)});
    end
    pipe_ack_i = 1'b1;
    @(posedge sys_clk); #1;
    pipe_ack_i = 1'b0;
    total++;
    if ({busy, pipe_ack_o} !== 2'b01) begin
      bad++; $display("FAIL single_idle got=%b exp=01", {busy, pipe_ack_o});
    end
    load_square(s2);
    total++;
    if ({busy, cur_pos()} !== {1'b1, exp_pos(s2, 0)}) begin
      bad++; $display("FAIL b2b_first got=%h exp=%h", {busy, cur_pos()}, {1'b1, exp_pos(s2, 0)});
    end
    collect(20);
    total++;
    if (recs.size() != 3) begin
      bad++; $display("FAIL b2b_count got=%0d exp=3", recs.size());
    end
    for (int k = 0; k < recs.size(); k++) begin
      total++;
      if (recs[k].pos !== exp_pos(s2, k)) begin
        bad++; $display("FAIL b2b_line%0d got=%h exp=%h", k, recs[k].pos, exp_pos(s2, k));
      end
    end
  endtask

  task automatic test_async_reset();
    sq_t s, s2;
    s  = rand_sq(8, 8);
    s2 = rand_sq(5, 5);
    load_square(s);
    pipe_ack_i = 1'b1;
    @(posedge sys_clk); #1;
    pipe_ack_i = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    total++;
    if ({busy, pipe_stb_o, pipe_ack_o} !== 3'b001) begin
      bad++; $display("FAIL arst_hs got=%b exp=001", {busy, pipe_stb_o, pipe_ack_o});
    end
    total++;
    if ({cur_pos(), cur_dif()} !== 130'd0) begin
      bad++; $display("FAIL arst_data got=%h exp=0", {cur_pos(), cur_dif()});
    end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    total++;
    if (pipe_stb_o !== 1'b0) begin
      bad++; $display("FAIL arst_release got=%b exp=0", pipe_stb_o);
    end
    load_square(s2);
    collect(25);
    total++;
    if (recs.size() != 5) begin
      bad++; $display("FAIL arst_count got=%0d exp=5", recs.size());
    end
    for (int k = 0; k < recs.size(); k++) begin
      total++;
      if (recs[k].pos !== exp_pos(s2, k)) begin
        bad++; $display("FAIL arst_line%0d got=%h exp=%h", k, recs[k].pos, exp_pos(s2, k));
      end
    end
  endtask

  task automatic test_hdiff();
    sq_t s;
    s = rand_sq(3, 20);
    s.hxp = 1'b1; s.hxq = 7; s.hxr = 5;
    load_square(s);
    collect(40);
    total++;
    if (recs.size() != s.h) begin
      bad++; $display("FAIL hdiff_count got=%0d exp=%0d", recs.size(), s.h);
    end
    for (int k = 0; k < recs.size(); k++) begin
      total++;
      if ({recs[k].dif, recs[k].pos} !== {exp_dif(s), exp_pos(s, k)}) begin
        bad++; $display("FAIL hdiff_line%0d got=%h exp=%h", k,
                        {recs[k].dif, recs[k].pos}, {exp_dif(s), exp_pos(s, k)});
      end
    end
  endtask

  task automatic test_random();
    sq_t s;
    for (int n = 0; n < 6; n++) begin
      s = rand_sq(1, 24);
      load_square(s);
      collect(30);
      total++;
      if (recs.size() != s.h) begin
        bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, recs.size(), s.h);
      end
      for (int k = 0; k < recs.size(); k++) begin
        total++;
        if ({recs[k].dif, recs[k].pos} !== {exp_dif(s), exp_pos(s, k)}) begin
          bad++; $display("FAIL rand%0d_line%0d got=%h exp=%h", n, k,
                          {recs[k].dif, recs[k].pos}, {exp_dif(s), exp_pos(s, k)});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single_b2b();
    test_async_reset();
    test_hdiff();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
